freq_meter_gate_ctrl: RTL and testbench
=======================================

// Module: freq_meter_gate_ctrl
// PURPOSE
//  Parametrised gate-time controller for the frequency meter. It synchronises the external sample signal,
//  counts its rising edges in a BCD counter chain over a programmable gate window, and latches the result
//  with a valid pulse. Supports single-shot and continuous measurement and flags overflow. Sits between
//  the sample input pin and the display/register path, replacing the fixed mux-selected gate sequencer.
// PARAMETERS
//  NUM_DIGITS   5   BCD digits in the count / result (1..8)
//  GATE_W       24  width of gate-length field, in clk cycles
//  SYNC_STAGES  2   flops in sample_in synchroniser (>=2)
// PORTS
//  clk           in   1             single system clock, all logic on rising edge
//  reset         in   1             synchronous, active-high reset
//  sample_in     in   1             asynchronous signal under measurement
//  start         in   1             one-shot request; sampled only in IDLE
//  continuous    in   1             1 = restart automatically after each result
//  gate_cycles   in   GATE_W        gate length in clk cycles; captured on leaving IDLE
//  busy          out  1             1 in any state other than IDLE
//  result_digits out  4*NUM_DIGITS  latched BCD result, digit 0 = bits [3:0] (least significant)
//  result_ovf    out  1             latched overflow flag for result_digits
//  result_valid  out  1             one-cycle pulse when result_digits/result_ovf update
// BEHAVIOUR
//  Reset (sync): state=IDLE; result_digits=0, result_ovf=0, result_valid=0, busy=0; synchroniser, edge flop,
//   counter chain, gate timer all cleared. Reset mid-measurement aborts it; no valid pulse follows.
//  Edge detect: edge = sync_out & ~sync_prev; only edges detected while state==GATE are counted.
//  FSM (one transition per clk):
//   IDLE   : if (start|continuous) -> CLEAR; capture gate_len = (gate_cycles==0) ? 1 : gate_cycles.
//   CLEAR  : counter chain cleared, ovf cleared, timer = gate_len-1 -> GATE.
//   GATE   : inc counter on edge; timer-- ; when timer==0 (edge in that cycle still counted) -> SETTLE.
//            Exactly gate_len GATE cycles.
//   SETTLE : no counting; one cycle -> LATCH.
//   LATCH  : result_digits<=count, result_ovf<=ovf, result_valid<=1 (on edge leaving LATCH);
//            -> CLEAR if continuous else IDLE.
//  Latency: start sampled at edge E0; result_valid high after edge E0+gate_len+3 for exactly one cycle.
//   Continuous period = gate_len+3 cycles.
//  Counter: BCD ripple, digit wraps 9->0 with carry. At all-9s plus another edge: count saturates at all-9s,
//   ovf sets sticky until next CLEAR. Values 10..15 never occur in any digit.
//  start while busy: ignored. gate_cycles changes after capture: no effect on current gate.
//  continuous dropped mid-measurement: current measurement completes and latches, then IDLE.
//  continuous=1 and start=1 in IDLE: single entry to CLEAR (no double-start).
//  result_digits/result_ovf hold their last value between valid pulses.
// STRUCTURE
//  Package freq_meter_pkg: typedef enum logic[2:0] {IDLE,CLEAR,GATE,SETTLE,LATCH} fm_state_t;
//   typedef logic [3:0] bcd_digit_t; localparam bcd_digit_t BCD_MAX = 4'd9.
//  Sub-module bcd_counter_chain #(NUM_DIGITS): ports clk, reset, clr, inc, digits, ovf (saturating, sticky).
//  Top holds synchroniser, edge detect, gate timer, FSM, result registers.
// TESTING
//  1. gate_cycles=10, sample_in square wave period 2 clk, start pulse -> result_digits=BCD 00005, ovf=0,
//     result_valid one cycle, 13 edges after start sampled.
//  2. gate_cycles=200, period 2 -> 00100 (carry ripple across 2 digits); NUM_DIGITS=3, gate_cycles=2000
//     -> result 999, result_ovf=1.
//  3. continuous=1, gate_cycles=8, sample_in held 0 -> result 0 with valid every 11 cycles; drop continuous
//     mid-GATE -> one more valid, then busy=0.
//  4. start pulsed again and gate_cycles changed during GATE -> ignored; result and timing per original gate.
//  5. reset asserted mid-GATE -> next cycle busy=0, outputs 0, no result_valid for 50 cycles after.
//  6. gate_cycles=0, sample_in constant 1 after sync settled -> gate of 1 cycle, result 0, valid 4 edges after start.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter gate controller.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } fm_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Next value of a single BCD digit, wrapping 9 -> 0.
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    bcd_digit_t r;
    if (d == BCD_MAX) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_chain.sv
// Ripple BCD counter chain. Saturates at all-9s; a further increment sets a
// sticky overflow flag that only clr (or reset) removes.
module bcd_counter_chain
  import freq_meter_pkg::*;
#(
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    ovf
);

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    ovf_q, ovf_d;
  logic                    all_max;
  logic                    carry;

  // Next count: clear wins over increment; at all-9s the count holds and overflow latches.
  always_comb begin
    digits_d = digits_q;
    ovf_d    = ovf_q;
    all_max  = 1'b1;
    carry    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_q[4*i +: 4] != BCD_MAX) begin
        all_max = 1'b0;
      end
    end
    if (clr) begin
      digits_d = '0;
      ovf_d    = 1'b0;
    end else if (inc) begin
      if (all_max) begin
        ovf_d = 1'b1;
      end else begin
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (carry) begin
            digits_d[4*i +: 4] = bcd_inc(digits_q[4*i +: 4]);
            carry              = (digits_q[4*i +: 4] == BCD_MAX);
          end
        end
      end
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  assign digits = digits_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/freq_meter_gate_ctrl.sv
// Gate-time controller for the frequency meter: synchronises sample_in,
// counts its rising edges over a programmable gate window and latches the
// BCD result with a one-cycle valid pulse.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | waiting for start or continuous; gate length captured on exit
//  CLEAR  | counter chain and overflow cleared, gate timer loaded
//  GATE   | edges counted; timer runs down, exactly gate_len cycles
//  SETTLE | one quiet cycle, no counting
//  LATCH  | count copied to result registers, valid pulsed
module freq_meter_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int NUM_DIGITS  = 5,
  parameter int GATE_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_in,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [GATE_W-1:0]       gate_cycles,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] result_digits,
  output logic                    result_ovf,
  output logic                    result_valid
);

  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    sync_prev_q, sync_prev_d;
  logic                    sync_out;
  logic                    edge_det;

  fm_state_t               state_q, state_d;
  logic [GATE_W-1:0]       gate_len_q, gate_len_d;
  logic [GATE_W-1:0]       timer_q, timer_d;

  logic [4*NUM_DIGITS-1:0] result_digits_q, result_digits_d;
  logic                    result_ovf_q, result_ovf_d;
  logic                    result_valid_q, result_valid_d;

  logic                    cnt_clr;
  logic                    cnt_inc;
  logic [4*NUM_DIGITS-1:0] cnt_digits;
  logic                    cnt_ovf;

  // Synchroniser shift and previous-value flop for rising-edge detection.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], sample_in};
    sync_out    = sync_q[SYNC_STAGES-1];
    sync_prev_d = sync_out;
    edge_det    = sync_out & ~sync_prev_q;
  end

  // Next-state, gate timer, counter control and result capture.
  always_comb begin
    state_d         = state_q;
    gate_len_d      = gate_len_q;
    timer_d         = timer_q;
    result_digits_d = result_digits_q;
    result_ovf_d    = result_ovf_q;
    result_valid_d  = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A zero gate length would never close the window, so it becomes one cycle.
        if (start | continuous) begin
          state_d    = CLEAR;
          gate_len_d = (gate_cycles == '0) ? GATE_ONE : gate_cycles;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        timer_d = gate_len_q - GATE_ONE;
        state_d = GATE;
      end
      GATE: begin
        // The edge seen in the terminal-count cycle is still counted.
        cnt_inc = edge_det;
        if (timer_q == '0) begin
          state_d = SETTLE;
        end else begin
          timer_d = timer_q - GATE_ONE;
        end
      end
      SETTLE: begin
        state_d = LATCH;
      end
      LATCH: begin
        result_digits_d = cnt_digits;
        result_ovf_d    = cnt_ovf;
        result_valid_d  = 1'b1;
        state_d         = continuous ? CLEAR : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All controller registers; reset aborts any measurement in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q          <= '0;
      sync_prev_q     <= 1'b0;
      state_q         <= IDLE;
      gate_len_q      <= GATE_ONE;
      timer_q         <= '0;
      result_digits_q <= '0;
      result_ovf_q    <= 1'b0;
      result_valid_q  <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      sync_prev_q     <= sync_prev_d;
      state_q         <= state_d;
      gate_len_q      <= gate_len_d;
      timer_q         <= timer_d;
      result_digits_q <= result_digits_d;
      result_ovf_q    <= result_ovf_d;
      result_valid_q  <= result_valid_d;
    end
  end

  bcd_counter_chain #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .digits(cnt_digits),
    .ovf   (cnt_ovf)
  );

  assign busy          = (state_q != IDLE);
  assign result_digits = result_digits_q;
  assign result_ovf    = result_ovf_q;
  assign result_valid  = result_valid_q;

endmodule

// File: tb/tb_freq_meter_gate_ctrl.sv
// Scoreboard bench: two instances (5 and 3 digits) share one stimulus stream.
// The reference model works from the recorded sample history and measurement
// timestamps; a negedge monitor pops expectations when a result appears.
module tb_freq_meter_gate_ctrl;

  localparam int GW = 24;
  localparam int S  = 2;
  localparam int HMAX = 65536;

  logic          clk = 1'b0;
  logic          reset, sample_in, start, continuous;
  logic [GW-1:0] gate_cycles;

  logic          busy5, ovf5, valid5;
  logic [19:0]   dig5;
  logic          busy3, ovf3, valid3;
  logic [11:0]   dig3;

  always #5 clk = ~clk;

  freq_meter_gate_ctrl #(.NUM_DIGITS(5), .GATE_W(GW), .SYNC_STAGES(S)) dut5 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .start(start),
    .continuous(continuous), .gate_cycles(gate_cycles), .busy(busy5),
    .result_digits(dig5), .result_ovf(ovf5), .result_valid(valid5));

  freq_meter_gate_ctrl #(.NUM_DIGITS(3), .GATE_W(GW), .SYNC_STAGES(S)) dut3 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .start(start),
    .continuous(continuous), .gate_cycles(gate_cycles), .busy(busy3),
    .result_digits(dig3), .result_ovf(ovf3), .result_valid(valid3));

  typedef struct {
    int cnt;
    bit ovf;
    int vedge;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hist [HMAX];
  bit   active = 1'b0;
  int   e0 = 0;
  int   gl = 1;
  bit   busy_exp = 1'b0;
  int   last5 = 0, last3 = 0;
  bit   lovf5 = 1'b0, lovf3 = 1'b0;
  int   smode = 0;
  bit   run_mon = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, cyc - 1);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r;
    int v;
    r = '0;
    v = n;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int h(input int i);
    return (i < 0) ? 0 : int'(hist[i]);
  endfunction

  // Reference model, evaluated once per rising edge with the inputs seen at that edge.
  task automatic model_edge();
    int k;
    int n;
    k = cyc;
    if (reset) begin
      active = 1'b0;
      for (int j = k - S; j <= k; j++) if (j >= 0) hist[j] = 1'b0;
      q5.delete();
      q3.delete();
      last5 = 0; last3 = 0; lovf5 = 1'b0; lovf3 = 1'b0;
    end else begin
      hist[k] = sample_in;
      if (active) begin
        if (k == e0 + gl) begin
          // rising edges of the synchronised sample over the gl gate cycles
          n = 0;
          for (int j = e0 + 1; j <= e0 + gl; j++) n += h(j - S + 1) & (1 - h(j - S));
          q5.push_back('{cnt: (n > 99999) ? 99999 : n, ovf: (n > 99999), vedge: e0 + gl + 3});
          q3.push_back('{cnt: (n > 999) ? 999 : n, ovf: (n > 999), vedge: e0 + gl + 3});
        end
        if (k == e0 + gl + 3) begin
          if (continuous) e0 = k;
          else active = 1'b0;
        end
      end else if (start | continuous) begin
        active = 1'b1;
        e0 = k;
        gl = (gate_cycles == '0) ? 1 : int'(gate_cycles);
      end
    end
    busy_exp = active;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    case (smode)
      0: sample_in = 1'b0;
      1: sample_in = 1'b1;
      2: sample_in = ~sample_in;
      default: sample_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy_exp && n < lim) begin
      tick();
      n++;
    end
    cmp("idle_timeout", 32'(busy_exp), 32'd0);
    repeat (2) tick();
  endtask

  task automatic measure(input int g, input int lim);
    gate_cycles = GW'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(lim);
  endtask

  // Monitor: compare busy every cycle; pop an expectation when a result is due.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (run_mon) begin
      cmp("busy5", 32'(busy5), 32'(busy_exp));
      cmp("busy3", 32'(busy3), 32'(busy_exp));

      ev = (q5.size() > 0) && (q5[0].vedge == cyc - 1);
      cmp("valid5", 32'(valid5), 32'(ev));
      if (ev) begin
        e = q5.pop_front();
        last5 = e.cnt; lovf5 = e.ovf;
      end else if (q5.size() > 0 && q5[0].vedge < cyc - 1) begin
        void'(q5.pop_front());
      end
      cmp("digits5", 32'(dig5), to_bcd(last5));
      cmp("ovf5", 32'(ovf5), 32'(lovf5));

      ev = (q3.size() > 0) && (q3[0].vedge == cyc - 1);
      cmp("valid3", 32'(valid3), 32'(ev));
      if (ev) begin
        e = q3.pop_front();
        last3 = e.cnt; lovf3 = e.ovf;
      end else if (q3.size() > 0 && q3[0].vedge < cyc - 1) begin
        void'(q3.pop_front());
      end
      cmp("digits3", 32'(dig3), to_bcd(last3));
      cmp("ovf3", 32'(ovf3), 32'(lovf3));
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; gate_cycles = '0; sample_in = 1'b0;
    tick();
    run_mon = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // basic gate, square wave period 2
    smode = 2;
    measure(10, 100);
    // carry ripple, then 3-digit saturation with overflow
    measure(200, 400);
    measure(2000, 2200);

    // continuous with idle input, then drop continuous mid-gate
    smode = 0;
    gate_cycles = GW'(8);
    continuous = 1'b1;
    repeat (40) tick();
    continuous = 1'b0;
    wait_idle(100);

    // start and gate_cycles changes while busy are ignored
    smode = 3;
    gate_cycles = GW'(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    gate_cycles = GW'(5);
    tick();
    start = 1'b0;
    wait_idle(100);

    // reset mid-gate aborts, no valid follows
    smode = 2;
    gate_cycles = GW'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (50) tick();

    // zero gate length with constant-high input
    smode = 1;
    repeat (5) tick();
    measure(0, 50);

    // randomized sessions
    for (int r = 0; r < 25; r++) begin
      smode = $urandom_range(0, 3);
      gate_cycles = GW'($urandom_range(0, 40));
      continuous = ($urandom_range(0, 3) == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat ($urandom_range(0, 60)) begin
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) continuous = ~continuous;
        if ($urandom_range(0, 9) == 0) gate_cycles = GW'($urandom_range(0, 40));
        reset = ($urandom_range(0, 60) == 0);
        tick();
      end
      start = 1'b0;
      continuous = 1'b0;
      reset = 1'b0;
      wait_idle(200);
    end

    repeat (5) tick();
    cmp("queue5_drained", 32'(q5.size()), 32'd0);
    cmp("queue3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
